instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the CPU. It holds the program counter, issues word reads to instruction memory over a request/response handshake, and buffers returned words in a small FIFO. It presents the words as `code` to the downstream decode stage, `instruction_interpreter`, with a valid/ready handshake. Branch/jump redirects from the execute stage flush the buffer and discard any in-flight response.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded at reset. Bits [1:0] are ignored.
- `DEPTH`, 2: number of fetch-buffer entries. Legal values are 2 to 8.
- `clk`  input  1: the only clock; all state updates on its rising edge.
- `rst_n`  input  1: synchronous, active-low reset.
- `imem_req`  output  1: read request; combinational.
- `imem_addr`  output  32: word-aligned read address; equals the current fetch PC.
- `imem_ready`  input  1: memory accepts the request this cycle.
- `imem_rvalid`  input  1: read data valid.
- `imem_rdata`  input  32: read data.
- `redirect`  input  1: flush the stage and restart fetch at `redirect_pc`.
- `redirect_pc`  input  32: new PC; bits [1:0] are forced to 0.
- `code`  output  32: instruction at the buffer head; 32'h0 when the buffer is empty.
- `pc_out`  output  32: PC of `code`; 32'h0 when the buffer is empty.
- `code_valid`  output  1: buffer is not empty.
- `decode_ready`  input  1: downstream consumes the head entry when `code_valid` is also 1.
- `fetch_count`  output  32: count of delivered instructions (see Configuration).

## Operation
- State machine with three states: IDLE, WAIT, DROP.
- IDLE:
  - `imem_req` = (count < DEPTH) && !redirect.
  - On `imem_req && imem_ready`: latch the request PC, fetch_pc += 4, go to WAIT.
- WAIT: on `imem_rvalid`, push {request PC, `imem_rdata`} into the buffer and go to IDLE.
  - There is at most one outstanding request.
  - A slot is reserved at issue, so a push never overflows the buffer.
- DROP: on `imem_rvalid`, discard the data and go to IDLE. `imem_req` stays 0 while in DROP.
- `redirect` has the highest priority and acts in any state:
  - The buffer is emptied.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - In WAIT without `imem_rvalid`: go to DROP.
  - In WAIT with `imem_rvalid` in the same cycle: the data is discarded; go to IDLE.
  - In DROP: stay in DROP.
  - Any pop in the same cycle is ignored.
- Pop occurs when `code_valid && decode_ready` and `redirect` is 0.
  - Push and pop in the same cycle are both performed; count is unchanged.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 32'h0.
- `imem_rdata` is passed through unmodified; decoding is not this stage's job.

## Timing
- Reset values:
  - fetch_pc = RESET_PC & ~3; state = IDLE; buffer empty.
  - `code` = 0, `pc_out` = 0, `code_valid` = 0, `fetch_count` = 0.
  - `imem_req` = 0 while `rst_n` is 0.
- A reset in mid-transaction abandons the outstanding request. The memory must not return data for it after reset.
- The first `imem_req` is asserted in the first cycle with `rst_n` = 1.
- `imem_rvalid` is legal no earlier than one cycle after the accepting cycle.
- `code_valid` rises one cycle after the `imem_rvalid` push.
- Peak throughput is one instruction per 2 cycles (issue cycle, then response cycle).
- Redirect to new data:
  - The redirect cycle sets `code_valid` to 0 on the next edge.
  - The request to `redirect_pc` issues in the next cycle, or after the drained response if the stage was in DROP.

## Configuration
- Macro `FETCH_PERF_EN`.
- Defined: `fetch_count` increments by 1 on every pop. It wraps at 2^32, is cleared by reset, and is not cleared by `redirect`.
- Undefined: no counter register is built and `fetch_count` is tied to 32'h0.

## Test plan
- Reset with RESET_PC = 32'h100, memory returning rvalid 1 cycle after each accept, decode_ready = 1:
  - addresses 0x100, 0x104, 0x108 are issued on alternating cycles;
  - `code`/`pc_out` follow in order.
- decode_ready = 0 with DEPTH = 2:
  - after two pushes, `imem_req` stays 0 and `code` holds the first word;
  - raising decode_ready resumes requests at 0x108.
- redirect to 32'h203 while in WAIT, with rvalid arriving 3 cycles later:
  - the late data is dropped;
  - the next `imem_addr` is 32'h200;
  - `code_valid` is 0 until the 0x200 data arrives.
- redirect in the same cycle as rvalid:
  - the data is discarded and no entry appears;
  - `imem_req` to the new PC is asserted on the following cycle.
- PC wrap: redirect to 32'hFFFF_FFFC, then two fetches → addresses 0xFFFF_FFFC and 0x0000_0000.
- FETCH_PERF_EN defined: 5 pops and one redirect → `fetch_count` = 5; with the macro undefined, `fetch_count` = 0.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, single-outstanding imem reads, fetch buffer feeding decode.
// Optional FETCH_PERF_EN builds the delivered-instruction counter behind fetch_count.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  instruction_fetch_if.master        imem,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic [31:0]                code,
  output logic [31:0]                pc_out,
  output logic                       code_valid,
  input  logic                       decode_ready,
  output logic [31:0]                fetch_count
);

  localparam int unsigned   PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state;
  state_t        next_state;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   buf_pc   [DEPTH];
  logic [31:0]   buf_code [DEPTH];
  logic          req;
  logic          accept;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign code_valid     = (count != '0);
  assign pop            = code_valid && decode_ready && !redirect;
  assign accept         = req && imem.imem_ready;
  assign imem.imem_req  = req;
  assign imem.imem_addr = fetch_pc;
  assign code           = code_valid ? buf_code[rd_ptr] : 32'h0;
  assign pc_out         = code_valid ? buf_pc[rd_ptr]   : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // A response arriving in DROP always ends the drain, even alongside a new
  // redirect; otherwise the stage would wait forever for a second response.
  always_comb begin
    next_state = state;
    req        = 1'b0;
    push       = 1'b0;
    unique case (state)
      IDLE: begin
        req = rst_n && !redirect && (count < DEPTH_C);
        if (req && imem.imem_ready) next_state = WAIT;
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          push       = !redirect;
          next_state = IDLE;
        end else if (redirect) begin
          next_state = DROP;
        end
      end
      DROP: begin
        if (imem.imem_rvalid) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC & ~32'h3;
      req_pc   <= 32'h0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~32'h3;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (accept) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]   <= req_pc;
      buf_code[wr_ptr] <= imem.imem_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_count;

  always_ff @(posedge clk) begin
    if (!rst_n)   perf_count <= 32'h0;
    else if (pop) perf_count <= perf_count + 32'd1;
  end

  assign fetch_count = perf_count;
`else
  assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_instruction_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          DEPTH    = 2;
`ifdef FETCH_PERF_EN
  localparam logic [31:0] PERF_EXP = 32'd5;
`else
  localparam logic [31:0] PERF_EXP = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        decode_ready = 1'b0;
  logic [31:0] code;
  logic [31:0] pc_out;
  logic        code_valid;
  logic [31:0] fetch_count;

  instruction_fetch_if imem_bus ();

  instruction_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem         (imem_bus),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .code         (code),
    .pc_out       (pc_out),
    .code_valid   (code_valid),
    .decode_ready (decode_ready),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  // Reference model: buffer contents as a queue, one outstanding read tracked by flags.
  logic [31:0] q_pc[$];
  logic [31:0] q_code[$];
  logic [31:0] issued[$];
  int          issue_cyc[$];
  logic [31:0] popped[$];
  bit          m_busy = 1'b0;
  bit          m_drop = 1'b0;
  logic [31:0] m_out_pc = 32'h0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_fcnt = 32'h0;
  int          pops = 0;
  int          cyc = 0;
  bit          just_acc = 1'b0;
  int          wait_cnt = 0;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic bit exp_req();
    return rst_n && !m_busy && (q_pc.size() < DEPTH) && !redirect;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkOutput();
    logic [31:0] ec;
    logic [31:0] ep;
    bit          ev;
    ev = (q_pc.size() != 0);
    ec = ev ? q_code[0] : 32'h0;
    ep = ev ? q_pc[0]   : 32'h0;
    check32("code",        code,                       ec);
    check32("pc_out",      pc_out,                     ep);
    check32("code_valid",  {31'b0, code_valid},        {31'b0, ev});
    check32("imem_req",    {31'b0, imem_bus.imem_req}, {31'b0, exp_req()});
    check32("imem_addr",   imem_bus.imem_addr,         m_pc);
    check32("fetch_count", fetch_count,                m_fcnt);
  endtask

  task automatic modelUpdate();
    bit acc;
    bit pop_now;
    cyc++;
    just_acc = 1'b0;
    if (!rst_n) begin
      m_pc   = RESET_PC & ~32'h3;
      q_pc.delete();
      q_code.delete();
      m_busy = 1'b0;
      m_drop = 1'b0;
      m_fcnt = 32'h0;
    end else begin
      acc     = exp_req() && imem_bus.imem_ready;
      pop_now = (q_pc.size() != 0) && decode_ready && !redirect;
      if (redirect) begin
        q_pc.delete();
        q_code.delete();
        m_pc = redirect_pc & ~32'h3;
        if (m_busy) begin
          if (imem_bus.imem_rvalid) begin
            m_busy = 1'b0;
            m_drop = 1'b0;
          end else begin
            m_drop = 1'b1;
          end
        end
      end else begin
        if (pop_now) begin
          popped.push_back(q_pc[0]);
          void'(q_pc.pop_front());
          void'(q_code.pop_front());
          pops++;
`ifdef FETCH_PERF_EN
          m_fcnt = m_fcnt + 32'd1;
`endif
        end
        if (m_busy && imem_bus.imem_rvalid) begin
          if (!m_drop) begin
            q_pc.push_back(m_out_pc);
            q_code.push_back(imem_bus.imem_rdata);
          end
          m_busy = 1'b0;
          m_drop = 1'b0;
        end
        if (acc) begin
          m_busy   = 1'b1;
          m_drop   = 1'b0;
          m_out_pc = m_pc;
          m_pc     = m_pc + 32'd4;
          issued.push_back(m_out_pc);
          issue_cyc.push_back(cyc);
          just_acc = 1'b1;
        end
      end
    end
  endtask

  // Memory responder: answers the outstanding read 1..max_delay+1 cycles after acceptance.
  task automatic mem_drive(input int max_delay);
    if (just_acc) wait_cnt = $urandom_range(0, max_delay);
    imem_bus.imem_rdata = $urandom;
    if (m_busy && rst_n) begin
      if (wait_cnt == 0) begin
        imem_bus.imem_rvalid = 1'b1;
      end else begin
        wait_cnt--;
        imem_bus.imem_rvalid = 1'b0;
      end
    end else begin
      imem_bus.imem_rvalid = 1'b0;
    end
  endtask

  task automatic applyStimulus();
    rst_n               = ($urandom_range(0, 199) != 0);
    redirect            = ($urandom_range(0, 15) == 0);
    redirect_pc         = $urandom;
    imem_bus.imem_ready = ($urandom_range(0, 3) != 0);
    decode_ready        = ($urandom_range(0, 2) != 0);
    mem_drive(3);
  endtask

  task automatic sample();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic advance();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic do_reset();
    rst_n                = 1'b0;
    redirect             = 1'b0;
    decode_ready         = 1'b0;
    imem_bus.imem_ready  = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    advance();
    sample();
    check32("rst code_valid",  {31'b0, code_valid},        32'h0);
    check32("rst code",        code,                       32'h0);
    check32("rst pc_out",      pc_out,                     32'h0);
    check32("rst imem_req",    {31'b0, imem_bus.imem_req}, 32'h0);
    check32("rst fetch_count", fetch_count,                32'h0);
    check32("rst imem_addr",   imem_bus.imem_addr,         32'h0000_0100);
    advance();
    rst_n = 1'b1;
    issued.delete();
    issue_cyc.delete();
    popped.delete();
    pops     = 0;
    wait_cnt = 0;
  endtask

  initial begin
    int guard;
    imem_bus.imem_ready  = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = 32'h0;

    // Streaming at peak rate from RESET_PC
    do_reset();
    imem_bus.imem_ready = 1'b1;
    decode_ready        = 1'b1;
    mem_drive(0);
    sample();
    check32("first req",  {31'b0, imem_bus.imem_req}, 32'h1);
    check32("first addr", imem_bus.imem_addr,         32'h0000_0100);
    advance();
    repeat (9) begin
      mem_drive(0);
      sample();
      advance();
    end
    check32("stream issued", issued.size(), 32'd5);
    if (issued.size() >= 3 && popped.size() >= 2) begin
      check32("stream addr0", issued[0], 32'h0000_0100);
      check32("stream addr1", issued[1], 32'h0000_0104);
      check32("stream addr2", issued[2], 32'h0000_0108);
      check32("stream spacing", issue_cyc[1] - issue_cyc[0], 32'd2);
      check32("stream pop0", popped[0], 32'h0000_0100);
      check32("stream pop1", popped[1], 32'h0000_0104);
    end

    // Back-pressure fills the buffer and stalls requests
    do_reset();
    imem_bus.imem_ready = 1'b1;
    decode_ready        = 1'b0;
    repeat (8) begin
      mem_drive(0);
      sample();
      advance();
    end
    mem_drive(0);
    sample();
    check32("full req",    {31'b0, imem_bus.imem_req}, 32'h0);
    check32("full valid",  {31'b0, code_valid},        32'h1);
    check32("full pc_out", pc_out,                     32'h0000_0100);
    advance();
    decode_ready = 1'b1;
    mem_drive(0);
    sample();
    advance();
    mem_drive(0);
    sample();
    check32("resume req",  {31'b0, imem_bus.imem_req}, 32'h1);
    check32("resume addr", imem_bus.imem_addr,         32'h0000_0108);
    advance();

    // Redirect while waiting, late response is dropped
    do_reset();
    imem_bus.imem_ready  = 1'b1;
    decode_ready         = 1'b1;
    imem_bus.imem_rvalid = 1'b0;
    sample();
    advance();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0203;
    sample();
    check32("rdw req", {31'b0, imem_bus.imem_req}, 32'h0);
    advance();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      imem_bus.imem_rvalid = (i == 2);
      imem_bus.imem_rdata  = 32'hBAD0_0100;
      sample();
      check32("drop req",   {31'b0, imem_bus.imem_req}, 32'h0);
      check32("drop valid", {31'b0, code_valid},        32'h0);
      advance();
    end
    imem_bus.imem_rvalid = 1'b0;
    sample();
    check32("after drop req",   {31'b0, imem_bus.imem_req}, 32'h1);
    check32("after drop addr",  imem_bus.imem_addr,         32'h0000_0200);
    check32("after drop valid", {31'b0, code_valid},        32'h0);
    advance();
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'hCAFE_0200;
    sample();
    check32("pre data valid", {31'b0, code_valid}, 32'h0);
    advance();
    imem_bus.imem_rvalid = 1'b0;
    decode_ready         = 1'b0;
    sample();
    check32("new valid",  {31'b0, code_valid}, 32'h1);
    check32("new pc_out", pc_out,              32'h0000_0200);
    check32("new code",   code,                32'hCAFE_0200);
    advance();

    // Redirect coinciding with the response
    do_reset();
    imem_bus.imem_ready  = 1'b1;
    decode_ready         = 1'b1;
    imem_bus.imem_rvalid = 1'b0;
    sample();
    advance();
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'hDEAD_0100;
    redirect             = 1'b1;
    redirect_pc          = 32'h0000_0300;
    sample();
    advance();
    redirect             = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    sample();
    check32("same req",   {31'b0, imem_bus.imem_req}, 32'h1);
    check32("same addr",  imem_bus.imem_addr,         32'h0000_0300);
    check32("same valid", {31'b0, code_valid},        32'h0);
    advance();
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'h1234_0300;
    sample();
    advance();
    imem_bus.imem_rvalid = 1'b0;
    sample();
    check32("same new pc",   pc_out, 32'h0000_0300);
    check32("same new code", code,   32'h1234_0300);
    advance();

    // PC wrap-around
    do_reset();
    imem_bus.imem_ready  = 1'b1;
    decode_ready         = 1'b1;
    imem_bus.imem_rvalid = 1'b0;
    redirect             = 1'b1;
    redirect_pc          = 32'hFFFF_FFFC;
    sample();
    advance();
    redirect = 1'b0;
    issued.delete();
    repeat (6) begin
      mem_drive(0);
      sample();
      advance();
    end
    check32("wrap issued", {31'b0, issued.size() >= 2}, 32'h1);
    if (issued.size() >= 2) begin
      check32("wrap addr0", issued[0], 32'hFFFF_FFFC);
      check32("wrap addr1", issued[1], 32'h0000_0000);
    end

    // Delivered-instruction counter survives a redirect
    do_reset();
    imem_bus.imem_ready = 1'b1;
    guard = 0;
    while (pops < 5 && guard < 200) begin
      decode_ready = 1'b1;
      mem_drive(0);
      sample();
      advance();
      guard++;
    end
    check32("perf pops", pops, 32'd5);
    redirect     = 1'b1;
    redirect_pc  = 32'h0000_0400;
    decode_ready = 1'b1;
    mem_drive(0);
    sample();
    advance();
    redirect     = 1'b0;
    decode_ready = 1'b0;
    repeat (3) begin
      mem_drive(0);
      sample();
      advance();
    end
    mem_drive(0);
    sample();
    check32("perf fetch_count", fetch_count, PERF_EXP);
    advance();

    // Randomized traffic with redirects, stalls and occasional resets
    do_reset();
    repeat (2000) begin
      applyStimulus();
      sample();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
